// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter for the single unified instruction/data
// memory port. Only one memory transaction is in flight at a time. When both
// masters request together, the grant alternates between them. A watchdog
// ends a transaction with an error response if the memory never acknowledges.
//
// Ports:
//   i_clk, i_rstn        clock (rising edge), asynchronous active-low reset
//   i_m0_* / o_m0_*      master 0 (core): request fields in, ack/err/rdata out
//   i_m1_* / o_m1_*      master 1 (loader/debug): same as master 0
//   o_mem_*              registered memory request and its fields
//   i_mem_ack/rdata      one-cycle memory completion and its read data
//   o_busy               high while a transaction is in BUSY or RESP
//
// All outputs are registered, so no combinational path runs from any input
// to any output.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_m0_req,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [31:0]   i_m0_wdata,
  input  logic [3:0]    i_m0_be,
  output logic          o_m0_ack,
  output logic          o_m0_err,
  output logic [31:0]   o_m0_rdata,
  input  logic          i_m1_req,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [31:0]   i_m1_wdata,
  input  logic [3:0]    i_m1_be,
  output logic          o_m1_ack,
  output logic          o_m1_err,
  output logic [31:0]   o_m1_rdata,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_be,
  input  logic          i_mem_ack,
  input  logic [31:0]   i_mem_rdata,
  output logic          o_busy
);

  // A width of at least 1 keeps the counter legal when the watchdog is off.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t        state_reg, state_next;
  logic          sel_reg, sel_next;
  logic          last_grant_reg, last_grant_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          mem_req_reg, mem_req_next;
  logic          mem_we_reg, mem_we_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]   mem_wdata_reg, mem_wdata_next;
  logic [3:0]    mem_be_reg, mem_be_next;
  logic          busy_reg, busy_next;

  // Per-master views of the request side, indexed by master number.
  logic [1:0]           req;
  logic [1:0]           we;
  logic [1:0][AW-1:0]   addr;
  logic [1:0][31:0]     wdata;
  logic [1:0][3:0]      be;
  logic [1:0]           ack_vec;
  logic [1:0]           err_vec;
  logic [1:0][31:0]     rdata_vec;

  assign req   = {i_m1_req, i_m0_req};
  assign we    = {i_m1_we, i_m0_we};
  assign addr  = {i_m1_addr, i_m0_addr};
  assign wdata = {i_m1_wdata, i_m0_wdata};
  assign be    = {i_m1_be, i_m0_be};

  logic        any_req;
  logic        grant;
  logic        timeout_hit;
  logic        done;
  logic        done_err;
  logic [31:0] resp_data;

  // On a tie the master that did not win last time gets the grant.
  // last_grant resets to 1, so master 0 wins the first tie.
  always_comb begin
    any_req = |req;
    if (&req) grant = ~last_grant_reg;
    else      grant = req[1];
  end

  // The counter equals the number of BUSY cycles already spent, so this
  // flags the TIMEOUT-th cycle with o_mem_req high. When ack arrives in that
  // same cycle, the ack wins and no error is reported.
  always_comb begin
    timeout_hit = (TIMEOUT > 0) && (cnt_reg == CW'(TIMEOUT - 1));
    done        = (state_reg == BUSY) && (i_mem_ack || timeout_hit);
    done_err    = done && !i_mem_ack;
    resp_data   = (i_mem_ack && !mem_we_reg) ? i_mem_rdata : 32'h0;
  end

  // State register and the registered outputs it sequences.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg      <= IDLE;
      sel_reg        <= 1'b0;
      last_grant_reg <= 1'b1;
      cnt_reg        <= '0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_be_reg     <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      mem_be_reg     <= mem_be_next;
      busy_reg       <= busy_next;
    end
  end

  // Next-state logic. RESP always lasts exactly one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values for the registered memory-side outputs.
  always_comb begin
    sel_next        = sel_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = '0;
    mem_req_next    = mem_req_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    mem_be_next     = mem_be_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          sel_next        = grant;
          last_grant_next = grant;
          mem_req_next    = 1'b1;
          mem_we_next     = we[grant];
          mem_addr_next   = addr[grant];
          mem_wdata_next  = wdata[grant];
          mem_be_next     = be[grant];
        end
      end
      BUSY: begin
        // Saturate rather than wrap; with the watchdog off it stays at zero.
        if ((TIMEOUT > 0) && (cnt_reg != CW'(TIMEOUT))) cnt_next = cnt_reg + CW'(1);
        else                                            cnt_next = cnt_reg;
        if (done) mem_req_next = 1'b0;
      end
      default: ;
    endcase
    busy_next = (state_next != IDLE);
  end

  // Response registers, one set per master. Only the selected master sees
  // ack/err, and its rdata holds until its next completion.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    logic        ack_reg;
    logic        err_reg;
    logic [31:0] rdata_reg;
    logic        hit;

    assign hit = done && (sel_reg == 1'(gi));

    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        ack_reg   <= 1'b0;
        err_reg   <= 1'b0;
        rdata_reg <= '0;
      end else begin
        ack_reg <= hit;
        err_reg <= hit && done_err;
        if (hit) rdata_reg <= resp_data;
      end
    end

    assign ack_vec[gi]   = ack_reg;
    assign err_vec[gi]   = err_reg;
    assign rdata_vec[gi] = rdata_reg;
  end

  assign o_m0_ack    = ack_vec[0];
  assign o_m0_err    = err_vec[0];
  assign o_m0_rdata  = rdata_vec[0];
  assign o_m1_ack    = ack_vec[1];
  assign o_m1_err    = err_vec[1];
  assign o_m1_rdata  = rdata_vec[1];
  assign o_mem_req   = mem_req_reg;
  assign o_mem_we    = mem_we_reg;
  assign o_mem_addr  = mem_addr_reg;
  assign o_mem_wdata = mem_wdata_reg;
  assign o_mem_be    = mem_be_reg;
  assign o_busy      = busy_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int TO = 4;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_m0_req = 1'b0, i_m0_we = 1'b0;
  logic [AW-1:0] i_m0_addr = '0;
  logic [31:0]   i_m0_wdata = '0;
  logic [3:0]    i_m0_be = '0;
  logic          o_m0_ack, o_m0_err;
  logic [31:0]   o_m0_rdata;
  logic          i_m1_req = 1'b0, i_m1_we = 1'b0;
  logic [AW-1:0] i_m1_addr = '0;
  logic [31:0]   i_m1_wdata = '0;
  logic [3:0]    i_m1_be = '0;
  logic          o_m1_ack, o_m1_err;
  logic [31:0]   o_m1_rdata;
  logic          o_mem_req, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic [3:0]    o_mem_be;
  logic          i_mem_ack = 1'b0;
  logic [31:0]   i_mem_rdata = '0;
  logic          o_busy;

  mem_arbiter #(.AW(AW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_m0_req(i_m0_req), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr),
    .i_m0_wdata(i_m0_wdata), .i_m0_be(i_m0_be),
    .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(i_m1_req), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr),
    .i_m1_wdata(i_m1_wdata), .i_m1_be(i_m1_be),
    .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_rdata(o_m1_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // One single-master transaction plus its expected response.
  // lat = number of o_mem_req cycles before the memory acks; -1 = never.
  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    logic [31:0] mem_data;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_req_cyc;
  } vec_t;

  typedef struct {
    int          m;
    logic        err;
    logic [31:0] rdata;
    int          req_cyc;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  logic [31:0] rdata_model[2];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_expired(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no DUT response within the cycle budget", name);
  endtask

  task automatic set_master(input int m, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be);
    if (m == 0) begin
      i_m0_req = req; i_m0_we = we; i_m0_addr = addr; i_m0_wdata = wdata; i_m0_be = be;
    end else begin
      i_m1_req = req; i_m1_we = we; i_m1_addr = addr; i_m1_wdata = wdata; i_m1_be = be;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_acks"},  {62'h0, o_m1_ack, o_m0_ack}, 64'h0);
    check({tag, "_errs"},  {62'h0, o_m1_err, o_m0_err}, 64'h0);
    check({tag, "_rdata"}, {o_m1_rdata, o_m0_rdata}, 64'h0);
    check({tag, "_mem_req"}, {63'h0, o_mem_req}, 64'h0);
    check({tag, "_mem_fields"}, {27'h0, o_mem_we, o_mem_be, o_mem_wdata}, 64'h0);
    check({tag, "_mem_addr"}, {32'h0, o_mem_addr}, 64'h0);
    check({tag, "_busy"}, {63'h0, o_busy}, 64'h0);
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rstn = 1'b0;
    set_master(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_master(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    i_mem_ack = 1'b0;
    rdata_model[0] = '0;
    rdata_model[1] = '0;
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int   req_cyc = 0;
    bit   got = 0;
    set_master(v.m, 1'b1, v.we, v.addr, v.wdata, v.be);
    e.m = v.m; e.err = v.exp_err; e.rdata = v.exp_rdata; e.req_cyc = v.exp_req_cyc;
    sb.push_back(e);
    for (int c = 0; c < 30 && !got; c++) begin
      @(posedge i_clk); #1;
      if (o_mem_req) begin
        req_cyc++;
        if (req_cyc == 1) begin
          check("mem_addr", {32'h0, o_mem_addr}, {32'h0, v.addr});
          check("mem_we_be", {59'h0, o_mem_we, o_mem_be}, {59'h0, v.we, v.be});
          check("mem_wdata", {32'h0, o_mem_wdata}, {32'h0, v.wdata});
        end
        i_mem_ack   = (req_cyc == v.lat);
        i_mem_rdata = (req_cyc == v.lat) ? v.mem_data : 32'h0;
      end else begin
        i_mem_ack = 1'b0;
      end
      if (o_m0_ack || o_m1_ack) begin
        got = 1;
        e = sb.pop_front();
        rdata_model[e.m] = e.rdata;
        check("ack_vec", {62'h0, o_m1_ack, o_m0_ack}, 64'(2'b01 << e.m));
        check("err_vec", {62'h0, o_m1_err, o_m0_err}, 64'({1'b0, e.err} << e.m));
        check("m0_rdata", {32'h0, o_m0_rdata}, {32'h0, rdata_model[0]});
        check("m1_rdata", {32'h0, o_m1_rdata}, {32'h0, rdata_model[1]});
        check("req_cycles", 64'(req_cyc), 64'(e.req_cyc));
        check("resp_mem_req", {63'h0, o_mem_req}, 64'h0);
        check("resp_busy", {63'h0, o_busy}, 64'h1);
        $display("txn %0d: m%0d we=%0b addr=0x%08h req_cycles=%0d ack=%0b%0b err=%0b%0b rdata0=0x%08h rdata1=0x%08h",
                 idx, v.m, v.we, v.addr, req_cyc, o_m1_ack, o_m0_ack, o_m1_err, o_m0_err,
                 o_m0_rdata, o_m1_rdata);
        set_master(v.m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
    end
    if (!got) begin
      bound_expired("txn_ack");
      void'(sb.pop_front());
    end
    @(posedge i_clk); #1;
    check("idle_busy", {63'h0, o_busy}, 64'h0);
    check("ack_pulse", {62'h0, o_m1_ack, o_m0_ack}, 64'h0);
  endtask

  initial begin
    int grants;
    int req_cyc;
    int ord[4];
    logic [31:0] tie_addr[2];
    logic [31:0] tie_data;
    bit seen;

    vecs[0] = '{0, 1'b0, 32'h100, 32'h0,        4'hF,    2, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 2};
    vecs[1] = '{1, 1'b1, 32'h20,  32'h000000AB, 4'b0001, 1, 32'h55555555, 1'b0, 32'h0,        1};
    vecs[2] = '{0, 1'b0, 32'h104, 32'h0,        4'hF,   -1, 32'h11111111, 1'b1, 32'h0,        TO};
    vecs[3] = '{0, 1'b0, 32'h200, 32'h0,        4'hF,    3, 32'h12345678, 1'b0, 32'h12345678, 3};
    vecs[4] = '{1, 1'b0, 32'h40,  32'h0,        4'hF,   TO, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, TO};
    vecs[5] = '{1, 1'b0, 32'h44,  32'h0,        4'hF,   -1, 32'h22222222, 1'b1, 32'h0,        TO};
    vecs[6] = '{0, 1'b1, 32'h208, 32'hA5A5A5A5, 4'b1100, 1, 32'h77777777, 1'b0, 32'h0,        1};
    vecs[7] = '{1, 1'b0, 32'h48,  32'h0,        4'hF,    2, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 2};

    rdata_model[0] = '0;
    rdata_model[1] = '0;

    // Reset state, with requests and a stray memory ack present.
    i_m0_req = 1'b1; i_m0_addr = 32'h444;
    i_mem_ack = 1'b1;
    #2;
    check_all_zero("reset");
    @(posedge i_clk); #1;
    check_all_zero("reset_held");
    i_m0_req = 1'b0; i_m0_addr = '0; i_mem_ack = 1'b0;
    i_rstn = 1'b1;
    @(posedge i_clk); #1;

    // A memory ack in IDLE is ignored.
    i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF0000;
    @(posedge i_clk); #1;
    i_mem_ack = 1'b0;
    check("idle_ack_acks", {62'h0, o_m1_ack, o_m0_ack}, 64'h0);
    check("idle_ack_state", {62'h0, o_mem_req, o_busy}, 64'h0);
    $display("txn idle: stray mem ack, ack=%0b%0b busy=%0b", o_m1_ack, o_m0_ack, o_busy);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Both masters held from reset: grants alternate m0, m1, m0, m1.
    do_reset();
    ord = '{0, 1, 0, 1};
    tie_addr[0] = 32'h1000;
    tie_addr[1] = 32'h2000;
    set_master(0, 1'b1, 1'b0, tie_addr[0], 32'h0, 4'hF);
    set_master(1, 1'b1, 1'b0, tie_addr[1], 32'h0, 4'hF);
    grants = 0;
    req_cyc = 0;
    for (int c = 0; c < 60 && grants < 4; c++) begin
      @(posedge i_clk); #1;
      if (o_mem_req) begin
        req_cyc++;
        if (req_cyc == 1) check("tie_addr", {32'h0, o_mem_addr}, {32'h0, tie_addr[ord[grants]]});
        tie_data = 32'hA0000000 | 32'(grants);
        i_mem_ack = (req_cyc == 1);
        i_mem_rdata = tie_data;
      end else begin
        i_mem_ack = 1'b0;
      end
      if (o_m0_ack || o_m1_ack) begin
        tie_data = 32'hA0000000 | 32'(grants);
        check("tie_ack_vec", {62'h0, o_m1_ack, o_m0_ack}, 64'(2'b01 << ord[grants]));
        check("tie_rdata", {32'h0, (ord[grants] == 1) ? o_m1_rdata : o_m0_rdata}, {32'h0, tie_data});
        $display("txn tie %0d: granted ack=%0b%0b rdata0=0x%08h rdata1=0x%08h",
                 grants, o_m1_ack, o_m0_ack, o_m0_rdata, o_m1_rdata);
        grants++;
        req_cyc = 0;
      end
    end
    if (grants < 4) bound_expired("tie_grants");
    set_master(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_master(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    i_mem_ack = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;

    // Reset while BUSY, then a late memory ack: no master ack ever appears.
    set_master(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge i_clk); #1;
      if (o_mem_req) seen = 1;
    end
    if (!seen) bound_expired("rst_busy_req");
    #2;
    i_rstn = 1'b0;
    #1;
    check_all_zero("rst_busy");
    set_master(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'h13579BDF;
    for (int c = 0; c < 4; c++) begin
      @(posedge i_clk); #1;
      i_mem_ack = 1'b0;
      check("late_ack_acks", {62'h0, o_m1_ack, o_m0_ack}, 64'h0);
      check("late_ack_mem_req", {62'h0, o_mem_req, o_busy}, 64'h0);
      check("late_ack_rdata", {o_m1_rdata, o_m0_rdata}, 64'h0);
    end
    $display("txn reset: mid-BUSY reset then late ack, ack=%0b%0b mem_req=%0b", o_m1_ack, o_m0_ack, o_mem_req);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master arbiter for the core's single unified instruction/data memory port. Master 0 is the multicycle core (fetch and load/store). Master 1 is the program loader/debug port. The block sequences one memory transaction at a time with round-robin fairness, registered handshakes, and a bus-timeout watchdog so a non-responding memory cannot hang the core FSM.

Parameters:
AW, 32, address width in bits
TIMEOUT, 255, max cycles in BUSY waiting for i_mem_ack before an error response; 0 disables the watchdog

Ports:
i_clk  input  1  clock, rising edge
i_rstn  input  1  asynchronous active-low reset
i_m0_req  input  1  master 0 request; held high until o_m0_ack
i_m0_we  input  1  master 0 write enable
i_m0_addr  input  AW  master 0 byte address
i_m0_wdata  input  32  master 0 write data
i_m0_be  input  4  master 0 byte enables
o_m0_ack  output  1  one-cycle completion pulse to master 0
o_m0_err  output  1  timeout flag, valid with o_m0_ack
o_m0_rdata  output  32  read data, valid with o_m0_ack
i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, i_m1_be, o_m1_ack, o_m1_err, o_m1_rdata: same as master 0, for master 1
o_mem_req  output  1  memory request, held until ack or timeout
o_mem_we  output  1  memory write enable
o_mem_addr  output  AW  memory address
o_mem_wdata  output  32  memory write data
o_mem_be  output  4  memory byte enables
i_mem_ack  input  1  memory completion, one cycle
i_mem_rdata  input  32  memory read data, valid with i_mem_ack
o_busy  output  1  high in BUSY or RESP

Behaviour:
- Reset: state IDLE, last_grant=1, timeout counter=0. All outputs are 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, BUSY, RESP.
- IDLE: if any request is high, select a master and latch its we/addr/wdata/be into the o_mem_* registers. Set o_mem_req=1, set sel, go to BUSY. i_mem_ack is ignored in IDLE.
- Arbitration: only one request → grant it. Both requests → grant the master != last_grant. last_grant updates on each grant. After reset, master 0 wins a tie.
- BUSY: the o_mem_* registers are stable. The counter increments each cycle.
  - i_mem_ack=1: clear o_mem_req and go to RESP. For a read, capture i_mem_rdata into o_m<sel>_rdata. For a write, o_m<sel>_rdata=0. Set o_m<sel>_ack=1 and err=0.
  - Counter reaches TIMEOUT (TIMEOUT>0) with no ack: clear o_mem_req, go to RESP. Set o_m<sel>_ack=1, o_m<sel>_err=1, rdata=0.
  - Ack and timeout in the same cycle: ack wins, err=0.
- RESP: exactly one cycle, with ack (and err if timed out) high for the selected master only. The counter clears. The selected master's req is ignored this cycle; a held req is taken as a new request from the next IDLE. The other master may not be granted in RESP. Next state is IDLE.
- Rdata holds its value until the next ack to that master. Ack and err are single-cycle pulses.
- Latency: req seen in IDLE at cycle N → o_mem_req high at N+1. i_mem_ack at cycle M → o_ack at M+1 → IDLE at M+2. Minimum 3 cycles per transaction.
- Counter width is clog2(TIMEOUT+1) and it never wraps. With TIMEOUT=0, BUSY waits indefinitely.
- Masters must not change request fields while req is high and unacked. Changes after grant have no effect.
- Asynchronous reset mid-transaction: drop o_mem_req immediately and issue no ack. A late i_mem_ack after reset is ignored because the block is in IDLE.

Test Plan:
- m0 read addr 0x100, memory acks 2 cycles after o_mem_req with 0xDEADBEEF → o_mem_req high for 2 cycles, o_m0_ack pulse 1 cycle later with rdata=0xDEADBEEF, err=0.
- m0 and m1 both request from reset, each held → grants alternate m0, m1, m0, m1. o_mem_addr matches the granted master and each ack reaches only that master.
- m1 write 0x0000_00AB, be=4'b0001, to 0x20 → o_mem_we=1, be=0001, wdata=0xAB. o_m1_ack=1, rdata=0.
- TIMEOUT=4, memory never acks → o_mem_req high for exactly 4 cycles, then o_m0_ack=1 and o_m0_err=1 with rdata=0. The next request proceeds normally.
- Ack arrives in the same cycle the counter hits TIMEOUT → ack=1, err=0, data captured.
- i_rstn pulsed low while BUSY, then i_mem_ack high after release → all outputs 0 and no o_m*_ack ever asserted.
